// File: rtl/divider_nbit.sv
// divider_nbit: sequential radix-2 restoring divider, WIDTH-bit operands.
// Supports unsigned and two's-complement signed division, selected per
// operation. Signed results truncate toward zero, and the remainder takes
// the dividend's sign.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for i_strt; operands captured on the start edge
// S_CALC | one quotient bit per cycle, WIDTH cycles, down-counter paced
// S_FIX  | sign correction / special cases, result registers written
// S_DONE | o_done pulse cycle, returns to S_IDLE unconditionally
module divider_nbit #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_strt,
    input  logic             i_sgn,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_not_valid,
    output logic             o_ovf,
    output logic             o_done,
    output logic             o_idle
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    // Partial remainder. It is always below the divisor magnitude between
    // iterations, so its extra sign bit only exists transiently in w_trial.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_sgn;
    logic             r_neg_dvd;
    logic             r_neg_dvs;
    logic             r_div0;
    logic             r_ovf_case;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_not_valid;
    logic             r_ovf;
    logic             r_done;

    logic             w_neg_dvd;
    logic             w_neg_dvs;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div0;
    logic             w_ovf_case;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;

    // Operand conditioning at capture: magnitudes only in signed mode.
    always_comb begin
        w_neg_dvd  = i_sgn & i_dividend[WIDTH-1];
        w_neg_dvs  = i_sgn & i_divisor[WIDTH-1];
        w_dvd_mag  = w_neg_dvd ? (-i_dividend) : i_dividend;
        w_dvs_mag  = w_neg_dvs ? (-i_divisor) : i_divisor;
        w_div0     = (i_divisor == '0);
        w_ovf_case = i_sgn && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                           && (i_divisor == '1);
    end

    // One restoring step: shift {R,Q} left, trial-subtract the divisor.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, r_dvs_mag};
    end

    // Final sign correction of the magnitude results.
    always_comb begin
        w_quo_res = (r_sgn & (r_neg_dvd ^ r_neg_dvs)) ? (-r_quo) : r_quo;
        w_rem_res = (r_sgn & r_neg_dvd) ? (-r_rem) : r_rem;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; divide-by-zero skips the iteration phase.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_strt) begin
                    w_state_nxt = w_div0 ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs_mag  <= '0;
            r_dvd_raw  <= '0;
            r_sgn      <= 1'b0;
            r_neg_dvd  <= 1'b0;
            r_neg_dvs  <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf_case <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_strt) begin
                        r_sgn      <= i_sgn;
                        r_neg_dvd  <= w_neg_dvd;
                        r_neg_dvs  <= w_neg_dvs;
                        r_quo      <= w_dvd_mag;
                        r_rem      <= '0;
                        r_dvs_mag  <= w_dvs_mag;
                        r_dvd_raw  <= i_dividend;
                        r_div0     <= w_div0;
                        r_ovf_case <= w_ovf_case;
                        r_cnt      <= w_div0 ? '0 : CW'(WIDTH);
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: written only in S_FIX, done pulses the cycle after.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_not_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                if (r_div0) begin
                    r_quotient  <= '1;
                    r_remainder <= r_dvd_raw;
                    r_not_valid <= 1'b1;
                    r_ovf       <= 1'b0;
                end else begin
                    r_quotient  <= w_quo_res;
                    r_remainder <= w_rem_res;
                    r_not_valid <= 1'b0;
                    r_ovf       <= r_ovf_case;
                end
            end
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_not_valid = r_not_valid;
    assign o_ovf       = r_ovf;
    assign o_done      = r_done;
    assign o_idle      = (r_state == S_IDLE);

endmodule

// File: tb/tb_divider_nbit.sv
// Testbench for divider_nbit: four instances (WIDTH 8, 4, 16, 32) driven by
// directed cases and random operands, compared with an arithmetic model.
module tb_divider_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt [4];
    logic        sgn  [4];
    logic [31:0] dvd  [4];
    logic [31:0] dvs  [4];
    logic [31:0] q_w  [4];
    logic [31:0] r_w  [4];
    logic        nv_w [4];
    logic        ov_w [4];
    logic        dn_w [4];
    logic        id_w [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 16 : 32;
        logic [W-1:0] q_l;
        logic [W-1:0] r_l;
        divider_nbit #(.WIDTH(W)) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_strt     (strt[g]),
            .i_sgn      (sgn[g]),
            .i_dividend (dvd[g][W-1:0]),
            .i_divisor  (dvs[g][W-1:0]),
            .o_quotient (q_l),
            .o_remainder(r_l),
            .o_not_valid(nv_w[g]),
            .o_ovf      (ov_w[g]),
            .o_done     (dn_w[g]),
            .o_idle     (id_w[g])
        );
        assign q_w[g] = 32'(q_l);
        assign r_w[g] = 32'(r_l);
    end

    function automatic int wid(input int k);
        case (k)
            0:       return 8;
            1:       return 4;
            2:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign-interpreted values.
    task automatic model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic nv, output logic ov);
        longint m, ua, ub, sa, sb, qq, rr;
        m  = (longint'(1) <<< w) - 1;
        ua = longint'({32'd0, a}) & m;
        ub = longint'({32'd0, b}) & m;
        nv = 1'b0;
        ov = 1'b0;
        if (ub == 0) begin
            q  = 32'(m);
            r  = 32'(ua);
            nv = 1'b1;
            return;
        end
        if (!s) begin
            qq = ua / ub;
            rr = ua % ub;
        end else begin
            sa = ua[w-1] ? ua - (longint'(1) <<< w) : ua;
            sb = ub[w-1] ? ub - (longint'(1) <<< w) : ub;
            qq = sa / sb;
            rr = sa % sb;
            ov = (sa == -(longint'(1) <<< (w - 1))) && (sb == -1);
        end
        q = 32'(qq & m);
        r = 32'(rr & m);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (!id_w[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", id_w[k], 1);
    endtask

    task automatic run_op(input int k, input bit s, input logic [31:0] a, input logic [31:0] b);
        int w;
        int n;
        bit seen;
        logic [31:0] eq, er, m;
        logic env, eov;
        w = wid(k);
        m = mask_of(w);
        wait_idle(k);
        @(negedge clk);
        strt[k] = 1'b1; sgn[k] = s; dvd[k] = a; dvs[k] = b;
        @(posedge clk); #1;
        strt[k] = 1'b0; sgn[k] = 1'($urandom); dvd[k] = $urandom; dvs[k] = $urandom;
        check("idle_drop", id_w[k], 0);
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (dn_w[k]) seen = 1;
        end
        check("latency", n, ((b & m) == 0) ? 1 : w + 1);
        model(w, s, a, b, eq, er, env, eov);
        check("quotient", q_w[k], eq);
        check("remainder", r_w[k], er);
        check("not_valid", nv_w[k], env);
        check("ovf", ov_w[k], eov);
        @(posedge clk); #1;
        check("done_width", dn_w[k], 0);
        check("idle_back", id_w[k], 1);
        check("quotient_hold", q_w[k], eq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        logic [31:0] a, b, m;
        bit s;
        int w;

        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            strt[k] = 1'b0; sgn[k] = 1'b0; dvd[k] = '0; dvs[k] = '0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_q", q_w[k], 0);
            check("rst_r", r_w[k], 0);
            check("rst_flags", {nv_w[k], ov_w[k], dn_w[k]}, 0);
            check("rst_idle", id_w[k], 1);
        end
        @(negedge clk);
        rst = 1'b1;

        // Directed cases, WIDTH = 8.
        run_op(0, 0, 32'd200, 32'd7);
        check("u200_7_q", q_w[0], 28);
        check("u200_7_r", r_w[0], 4);
        run_op(0, 1, 32'hF9, 32'h02);
        check("sm7_2_q", q_w[0], 32'hFD);
        check("sm7_2_r", r_w[0], 32'hFF);
        run_op(0, 1, 32'h07, 32'hFE);
        check("s7_m2_q", q_w[0], 32'hFD);
        check("s7_m2_r", r_w[0], 32'h01);
        run_op(0, 0, 32'd13, 32'd0);
        check("div0_q", q_w[0], 32'hFF);
        check("div0_r", r_w[0], 13);
        check("div0_nv", nv_w[0], 1);
        run_op(0, 1, 32'h80, 32'hFF);
        check("ovf_q", q_w[0], 32'h80);
        check("ovf_r", r_w[0], 0);
        check("ovf_flag", ov_w[0], 1);
        run_op(0, 0, 32'h80, 32'hFF);
        check("u80_ff_q", q_w[0], 0);
        check("u80_ff_r", r_w[0], 32'h80);
        check("u80_ff_ovf", ov_w[0], 0);

        // Start pulse during CALC is ignored and not queued.
        wait_idle(0);
        @(negedge clk);
        strt[0] = 1'b1; sgn[0] = 1'b0; dvd[0] = 32'd200; dvs[0] = 32'd7;
        @(posedge clk); #1;
        strt[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        strt[0] = 1'b1; dvd[0] = 32'd5; dvs[0] = 32'd1;
        @(posedge clk); #1;
        strt[0] = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (dn_w[0]) seen = 1;
        end
        check("busy_done_seen", seen, 1);
        check("busy_q", q_w[0], 28);
        check("busy_r", r_w[0], 4);
        repeat (3) @(posedge clk);
        #1;
        check("busy_not_queued", id_w[0], 1);

        // Back-to-back with strt held high.
        wait_idle(0);
        @(negedge clk);
        strt[0] = 1'b1; sgn[0] = 1'b0; dvd[0] = 32'd100; dvs[0] = 32'd9;
        @(posedge clk); #1;
        n = 0;
        begin
            int first;
            int second;
            first = -1; second = -1;
            while (second < 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
                if (n == 11) begin
                    check("b2b_recapture", id_w[0], 0);
                    strt[0] = 1'b0;
                end
                if (dn_w[0]) begin
                    if (first < 0) first = n;
                    else second = n;
                end
            end
            check("b2b_first", first, 9);
            check("b2b_second", second, 20);
        end
        strt[0] = 1'b0;
        check("b2b_q", q_w[0], 11);
        check("b2b_r", r_w[0], 1);

        // Asynchronous reset mid-CALC on the 16-bit instance.
        run_op(2, 0, 32'd1000, 32'd3);
        wait_idle(2);
        @(negedge clk);
        strt[2] = 1'b1; sgn[2] = 1'b0; dvd[2] = 32'd5000; dvs[2] = 32'd7;
        @(posedge clk); #1;
        strt[2] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_q", q_w[2], 0);
        check("arst_r", r_w[2], 0);
        check("arst_flags", {nv_w[2], ov_w[2], dn_w[2]}, 0);
        check("arst_idle", id_w[2], 1);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            if (dn_w[2]) seen = 1;
        end
        check("arst_no_done", seen, 0);
        check("arst_idle_stays", id_w[2], 1);

        // Random sweep with corner patterns on every width.
        for (int k = 0; k < 4; k++) begin
            w = wid(k);
            m = mask_of(w);
            for (int i = 0; i < 40; i++) begin
                s = 1'($urandom);
                a = $urandom & m;
                b = $urandom & m;
                case (i % 8)
                    0: begin a = m; b = m; end
                    1: a = 0;
                    2: b = 1;
                    3: begin
                        if (b == 0) b = 1;
                        a = a % b;
                    end
                    4: b = 0;
                    5: begin a = 32'h1 << (w - 1); b = m; end
                    default: begin end
                endcase
                run_op(k, s, a, b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
